// File: rtl/axi_mem_slave.sv
// axi_mem_slave: AXI responder backed by a word-addressed memory; one write and one read burst in flight.
// Define AXI_MEM_SLAVE_RESP_ERR_EN to answer out-of-range beats and wlast/length mismatches with SLVERR.
`ifndef AXI_ADDR_WTH
`define AXI_ADDR_WTH 32
`endif
`ifndef AXI_DATA_WTH
`define AXI_DATA_WTH 32
`endif
`ifndef AXI_LEN_WTH
`define AXI_LEN_WTH 8
`endif
`ifndef AXI_RESP_WTH
`define AXI_RESP_WTH 2
`endif

module axi_mem_slave #(
  parameter int MEM_DEPTH_LOG2 = 12,
  parameter int BYTE_SHIFT     = $clog2(`AXI_DATA_WTH/8)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     ce,
  input  logic [`AXI_ADDR_WTH-1:0] awaddr,
  input  logic [`AXI_LEN_WTH-1:0]  awlen,
  input  logic                     awvalid,
  output logic                     awready,
  input  logic [`AXI_DATA_WTH-1:0] wdata,
  input  logic                     wlast,
  input  logic                     wvalid,
  output logic                     wready,
  output logic [`AXI_RESP_WTH-1:0] bresp,
  output logic                     bvalid,
  input  logic                     bready,
  input  logic [`AXI_ADDR_WTH-1:0] araddr,
  input  logic [`AXI_LEN_WTH-1:0]  arlen,
  input  logic                     arvalid,
  output logic                     arready,
  output logic [`AXI_DATA_WTH-1:0] rdata,
  output logic [`AXI_RESP_WTH-1:0] rresp,
  output logic                     rlast_d,
  output logic                     rvalid,
  input  logic                     rready
);
  localparam int ADDR_W = `AXI_ADDR_WTH;
  localparam int DATA_W = `AXI_DATA_WTH;
  localparam int LEN_W  = `AXI_LEN_WTH;
  localparam int RESP_W = `AXI_RESP_WTH;
  localparam int IDX_W  = ADDR_W - BYTE_SHIFT;
  localparam int DEPTH  = 1 << MEM_DEPTH_LOG2;
  localparam logic [RESP_W-1:0] RESP_OKAY   = '0;
  localparam logic [RESP_W-1:0] RESP_SLVERR = RESP_W'(2);

  typedef enum logic [1:0] {WR_IDLE, WR_DATA, WR_RESP} wr_state_t;
  typedef enum logic {RD_IDLE, RD_DATA} rd_state_t;

  // Reset asserts asynchronously but releases two edges after rst rises.
  logic [1:0] rst_sync_reg;
  logic       rst_n_int;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rst_sync_reg <= '0;
    else      rst_sync_reg <= {rst_sync_reg[0], 1'b1};
  end
  assign rst_n_int = rst_sync_reg[1];

  logic [DATA_W-1:0]         mem [DEPTH];
  logic [DATA_W-1:0]         ram_q;
  logic                      mem_we, mem_re;
  logic [MEM_DEPTH_LOG2-1:0] mem_waddr, mem_raddr;

  // Read and write on the same edge: the read sees the old word.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= wdata;
    if (mem_re) ram_q <= mem[mem_raddr];
  end

  wr_state_t         wr_state_reg, wr_state_next;
  logic [IDX_W-1:0]  wr_idx_reg, wr_idx_next;
  logic [LEN_W-1:0]  wr_cnt_reg, wr_cnt_next;
  logic              wr_err_reg, wr_err_next;
  logic [RESP_W-1:0] bresp_reg, bresp_next;
  logic              awready_reg, wready_reg, bvalid_reg;
  logic              aw_hs, w_hs, b_hs, wr_last_beat, wr_beyond;

  assign awready      = awready_reg & ce;
  assign wready       = wready_reg & ce;
  assign bvalid       = bvalid_reg;
  assign bresp        = bresp_reg;
  assign aw_hs        = awvalid & awready;
  assign w_hs         = wvalid & wready;
  assign b_hs         = bvalid_reg & bready & ce;
  assign wr_last_beat = (wr_cnt_reg == '0) | wlast;
`ifdef AXI_MEM_SLAVE_RESP_ERR_EN
  assign wr_beyond = (wr_idx_reg >> MEM_DEPTH_LOG2) != '0;
`else
  assign wr_beyond = 1'b0;
`endif

  always_comb begin
    wr_state_next = wr_state_reg;
    wr_idx_next   = wr_idx_reg;
    wr_cnt_next   = wr_cnt_reg;
    wr_err_next   = wr_err_reg;
    bresp_next    = bresp_reg;
    mem_we        = 1'b0;
    mem_waddr     = wr_idx_reg[MEM_DEPTH_LOG2-1:0];
    unique case (wr_state_reg)
      WR_IDLE: if (aw_hs) begin
        wr_idx_next   = IDX_W'(awaddr >> BYTE_SHIFT);
        wr_cnt_next   = awlen;
        wr_err_next   = 1'b0;
        wr_state_next = WR_DATA;
      end
      WR_DATA: if (w_hs) begin
        mem_we      = !wr_beyond;
        wr_idx_next = wr_idx_reg + IDX_W'(1);
        wr_cnt_next = wr_cnt_reg - LEN_W'(1);
`ifdef AXI_MEM_SLAVE_RESP_ERR_EN
        if (wr_beyond || ((wr_cnt_reg == '0) != wlast)) wr_err_next = 1'b1;
`endif
        if (wr_last_beat) begin
          wr_state_next = WR_RESP;
          bresp_next    = wr_err_next ? RESP_SLVERR : RESP_OKAY;
        end
      end
      WR_RESP: if (b_hs) wr_state_next = WR_IDLE;
      default: wr_state_next = WR_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n_int) begin
    if (!rst_n_int) begin
      wr_state_reg <= WR_IDLE;
      wr_idx_reg   <= '0;
      wr_cnt_reg   <= '0;
      wr_err_reg   <= 1'b0;
      bresp_reg    <= '0;
      awready_reg  <= 1'b0;
      wready_reg   <= 1'b0;
      bvalid_reg   <= 1'b0;
    end else if (ce) begin
      wr_state_reg <= wr_state_next;
      wr_idx_reg   <= wr_idx_next;
      wr_cnt_reg   <= wr_cnt_next;
      wr_err_reg   <= wr_err_next;
      bresp_reg    <= bresp_next;
      awready_reg  <= (wr_state_next == WR_IDLE);
      wready_reg   <= (wr_state_next == WR_DATA);
      bvalid_reg   <= (wr_state_next == WR_RESP);
    end
  end

  rd_state_t         rd_state_reg, rd_state_next;
  logic [IDX_W-1:0]  rd_idx_reg, rd_idx_next;
  logic [LEN_W-1:0]  rd_cnt_reg, rd_cnt_next;
  logic [RESP_W-1:0] rresp_reg, rresp_next;
  logic              rlast_reg, rlast_next;
  logic              rzero_reg, rzero_next;
  logic              arready_reg, rvalid_reg;
  logic              ar_hs, r_hs;

  assign arready = arready_reg & ce;
  assign rvalid  = rvalid_reg;
  assign rresp   = rresp_reg;
  assign rlast_d = rlast_reg;
  assign rdata   = rzero_reg ? '0 : ram_q;
  assign ar_hs   = arvalid & arready;
  assign r_hs    = rvalid_reg & rready & ce;

  always_comb begin
    rd_state_next = rd_state_reg;
    rd_idx_next   = rd_idx_reg;
    rd_cnt_next   = rd_cnt_reg;
    rresp_next    = rresp_reg;
    rlast_next    = rlast_reg;
    rzero_next    = rzero_reg;
    mem_re        = 1'b0;
    unique case (rd_state_reg)
      RD_IDLE: if (ar_hs) begin
        rd_idx_next   = IDX_W'(araddr >> BYTE_SHIFT);
        rd_cnt_next   = arlen;
        rlast_next    = (arlen == '0);
        mem_re        = 1'b1;
        rd_state_next = RD_DATA;
      end
      RD_DATA: if (r_hs) begin
        if (rd_cnt_reg == '0) begin
          rlast_next    = 1'b0;
          rd_state_next = RD_IDLE;
        end else begin
          rd_idx_next = rd_idx_reg + IDX_W'(1);
          rd_cnt_next = rd_cnt_reg - LEN_W'(1);
          rlast_next  = (rd_cnt_reg == LEN_W'(1));
          mem_re      = 1'b1;
        end
      end
      default: rd_state_next = RD_IDLE;
    endcase
    mem_raddr = rd_idx_next[MEM_DEPTH_LOG2-1:0];
    if (mem_re) begin
`ifdef AXI_MEM_SLAVE_RESP_ERR_EN
      rzero_next = (rd_idx_next >> MEM_DEPTH_LOG2) != '0;
      rresp_next = rzero_next ? RESP_SLVERR : RESP_OKAY;
`else
      rzero_next = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n_int) begin
    if (!rst_n_int) begin
      rd_state_reg <= RD_IDLE;
      rd_idx_reg   <= '0;
      rd_cnt_reg   <= '0;
      rresp_reg    <= '0;
      rlast_reg    <= 1'b0;
      rzero_reg    <= 1'b1;
      arready_reg  <= 1'b0;
      rvalid_reg   <= 1'b0;
    end else if (ce) begin
      rd_state_reg <= rd_state_next;
      rd_idx_reg   <= rd_idx_next;
      rd_cnt_reg   <= rd_cnt_next;
      rresp_reg    <= rresp_next;
      rlast_reg    <= rlast_next;
      rzero_reg    <= rzero_next;
      arready_reg  <= (rd_state_next == RD_IDLE);
      rvalid_reg   <= (rd_state_next == RD_DATA);
    end
  end

endmodule
